exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and interrupt sequencer between the memory (M) pipeline stage and `cp0`. It prioritises the exception flags of the instruction in M against pending interrupts, and picks one code per instruction. It presents that code to `cp0` as a single-cycle `excepttype` commit. It then flushes the pipeline and holds a redirect PC (exception vector or EPC for ERET) until fetch accepts it.

## Interface
- `VEC_RESET`, default 32'hBFC00200: vector base used when Status.BEV=1.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `inst_valid_i`, in, 1: M holds a real (non-bubble) instruction.
- `stallM_i`, in, 1: M stalled; no detection this cycle.
- `exc_flags_i`, in, 14: per-cause flags of the M instruction. Bit order is `exc_pkg::EXC_*`, listed in priority order in Operation.
- `eret_i`, in, 1: M instruction is ERET.
- `pc_i`, in, 32: M instruction PC.
- `in_delay_i`, in, 1: M instruction sits in a delay slot.
- `bad_addr_i`, in, 32: data-side faulting address.
- `status_i`, in, 32: CP0 Status.
- `cause_i`, in, 32: CP0 Cause.
- `epc_i`, in, 32: CP0 EPC.
- `ebase_i`, in, 32: CP0 EBase.
- `redirect_ready_i`, in, 1: fetch accepts the redirect this cycle.
- `excepttype_o`, out, 32: code to `cp0`; nonzero for exactly one cycle per event.
- `exc_pc_o`, out, 32: to `cp0` current_inst_addr.
- `exc_delay_o`, out, 1: to `cp0` is_in_delayslot.
- `exc_badaddr_o`, out, 32: to `cp0` bad_addr.
- `flush_o`, out, 1: kill F/D/E/M contents.
- `redirect_valid_o`, out, 1: redirect PC is valid.
- `redirect_pc_o`, out, 32: target PC.
- `busy_o`, out, 1: state != IDLE; upstream issue must stall.

## Operation
- FSM states: IDLE, COMMIT, REDIRECT.
- **Detection (IDLE only).** Requires `inst_valid_i & ~stallM_i`.
- **Interrupt condition:** `int_req = IE & ~EXL & ~ERL & |(cause_i[15:8] & status_i[15:8])`.
- **Priority, highest first, with code:**
  - INT 0x01
  - AdEL-fetch 0x04
  - TLB inst refill 0x10
  - TLB inst invalid 0x11
  - RI 0x0a
  - CpU 0x0b
  - Ov 0x0c
  - Trap 0x0d
  - Syscall 0x08
  - Break 0x09
  - AdEL-data 0x04
  - AdES 0x05
  - TLB data refill 0x12
  - TLB data invalid 0x13
  - TLB mod 0x14
  - ERET 0x0e, taken only if nothing above it is set.
- **On a hit, latch:** code, `pc_i`, `in_delay_i`, and the target.
- **Bad address latched:**
  - AdEL-fetch and TLB inst codes: `pc_i`.
  - All other codes: `bad_addr_i`.
- **Target:**
  - ERET: `epc_i`.
  - Otherwise: base + offset.
  - Base is `VEC_RESET` if `status_i[22]`, else `{ebase_i[31:12],12'h0}`.
  - Offset is 0x000 for TLB refill (0x10/0x12) when the pre-exception EXL=0; 0x180 otherwise.
- Target uses Status **before** `cp0` sets EXL.
- IDLE -> COMMIT on hit.
- **COMMIT, one cycle:**
  - `excepttype_o`, `exc_pc_o`, `exc_delay_o` and `exc_badaddr_o` are driven.
  - `flush_o`=1.
  - `redirect_valid_o`=1.
  - If `redirect_ready_i`=1, go to IDLE; else go to REDIRECT.
- **REDIRECT:**
  - `excepttype_o`=0, `flush_o`=1, `redirect_valid_o`=1, `redirect_pc_o` stable.
  - Go to IDLE on `redirect_ready_i`.
- **Outside COMMIT:** `excepttype_o`=0, and the `exc_*` outputs hold their last values.
- **Stall:** `stallM_i` in COMMIT/REDIRECT is ignored; the commit is never repeated.

## Timing
- Hit sampled at edge T; COMMIT is cycle T+1. `cp0` updates EPC/Cause/EXL at the end of T+1.
- Minimum event latency is 1 cycle (ready in COMMIT). Back-to-back events are ≥2 cycles apart, because IDLE is required for detection.
- **Reset:** state IDLE; all outputs 0, including `redirect_pc_o` and `busy_o`. Reset mid-COMMIT/REDIRECT aborts to IDLE with no further commit.
- An interrupt arriving while not IDLE is not lost: it is level-held in Cause and is re-evaluated on return to IDLE.
- `inst_valid_i`=0 with `int_req`=1: no event. Interrupts are taken only on a valid instruction, for a precise EPC.

## Configuration
- `EXC_TLB_EN` defined: the five TLB flags participate in the priority order and the refill offset rule applies.
- `EXC_TLB_EN` undefined: TLB flags are ignored, no 0x10–0x14 code is ever produced, and the offset is always 0x180.

## Structure
- Package `exc_pkg` holds:
  - the `EXC_*` flag bit indices;
  - the excepttype code constants (`EXCT_INT`…`EXCT_MOD`, `EXCT_ERET`);
  - the state enum;
  - the offsets 0x000/0x180.
- Natural sub-module `exc_prio_enc` (combinational): flags + `int_req` + `eret_i` -> {hit, code, fetch_side}.

## Test plan
- Syscall: `pc_i`=0x80001000, `in_delay_i`=0, BEV=0, EBase=0x80000000, ready=1. Expect one cycle of `excepttype_o`=0x08, `exc_pc_o`=0x80001000, `redirect_pc_o`=0x80000180, then IDLE.
- Interrupt vs. Ov: IE=1, EXL=0, IM2=IP2=1, Ov flag set. Expect code 0x01 (interrupt wins).
- Same setup with EXL=1: expect code 0x0c.
- ERET: `epc_i`=0xBFC00380, no flags. Expect code 0x0e and `redirect_pc_o`=0xBFC00380.
- TLB data refill with EXL=0, BEV=1, `bad_addr_i`=0x00402000. Expect code 0x12, `exc_badaddr_o`=0x00402000, `redirect_pc_o`=0xBFC00200. The same event with EXL=1 gives 0xBFC00380. With `EXC_TLB_EN` undefined: no event.
- Hold the redirect: ready=0 for 3 cycles. Expect `excepttype_o` nonzero only in the first cycle, and `flush_o`/`redirect_valid_o` high for 4 cycles. Asserting rst during REDIRECT returns all outputs to 0 the next cycle.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: flag bit indices (bit 0 is
// the highest-priority synchronous cause), excepttype codes, FSM states and
// vector offsets.
package exc_pkg;

    localparam int EXC_W = 14;

    localparam int EXC_ADEL_F = 0;
    localparam int EXC_TLBR_I = 1;
    localparam int EXC_TLBI_I = 2;
    localparam int EXC_RI     = 3;
    localparam int EXC_CPU    = 4;
    localparam int EXC_OV     = 5;
    localparam int EXC_TRAP   = 6;
    localparam int EXC_SYS    = 7;
    localparam int EXC_BP     = 8;
    localparam int EXC_ADEL_D = 9;
    localparam int EXC_ADES   = 10;
    localparam int EXC_TLBR_D = 11;
    localparam int EXC_TLBI_D = 12;
    localparam int EXC_MOD    = 13;

    // Flags that only exist when the TLB is built in.
    localparam logic [EXC_W-1:0] EXC_TLB_MASK =
        (14'd1 << EXC_TLBR_I) | (14'd1 << EXC_TLBI_I) |
        (14'd1 << EXC_TLBR_D) | (14'd1 << EXC_TLBI_D) | (14'd1 << EXC_MOD);

    localparam logic [7:0] EXCT_INT    = 8'h01;
    localparam logic [7:0] EXCT_ADEL   = 8'h04;
    localparam logic [7:0] EXCT_ADES   = 8'h05;
    localparam logic [7:0] EXCT_SYS    = 8'h08;
    localparam logic [7:0] EXCT_BP     = 8'h09;
    localparam logic [7:0] EXCT_RI     = 8'h0a;
    localparam logic [7:0] EXCT_CPU    = 8'h0b;
    localparam logic [7:0] EXCT_OV     = 8'h0c;
    localparam logic [7:0] EXCT_TRAP   = 8'h0d;
    localparam logic [7:0] EXCT_ERET   = 8'h0e;
    localparam logic [7:0] EXCT_TLBR_I = 8'h10;
    localparam logic [7:0] EXCT_TLBI_I = 8'h11;
    localparam logic [7:0] EXCT_TLBR_D = 8'h12;
    localparam logic [7:0] EXCT_TLBI_D = 8'h13;
    localparam logic [7:0] EXCT_MOD    = 8'h14;

    localparam logic [11:0] VEC_OFS_REFILL  = 12'h000;
    localparam logic [11:0] VEC_OFS_GENERAL = 12'h180;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    function automatic logic is_tlb_refill(input logic [7:0] code);
        return (code == EXCT_TLBR_I) || (code == EXCT_TLBR_D);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of M-stage, CP0, fetch-redirect and cp0-commit signals around exc_ctrl.
// slave: the sequencer itself; master: the pipeline/CP0 side driving it.
interface exc_ctrl_if;
    logic        inst_valid_i;
    logic        stallM_i;
    logic [13:0] exc_flags_i;
    logic        eret_i;
    logic [31:0] pc_i;
    logic        in_delay_i;
    logic [31:0] bad_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] ebase_i;
    logic        redirect_ready_i;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_delay_o;
    logic [31:0] exc_badaddr_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    modport slave (
        input  inst_valid_i, stallM_i, exc_flags_i, eret_i, pc_i, in_delay_i,
               bad_addr_i, status_i, cause_i, epc_i, ebase_i, redirect_ready_i,
        output excepttype_o, exc_pc_o, exc_delay_o, exc_badaddr_o, flush_o,
               redirect_valid_o, redirect_pc_o, busy_o
    );

    modport master (
        output inst_valid_i, stallM_i, exc_flags_i, eret_i, pc_i, in_delay_i,
               bad_addr_i, status_i, cause_i, epc_i, ebase_i, redirect_ready_i,
        input  excepttype_o, exc_pc_o, exc_delay_o, exc_badaddr_o, flush_o,
               redirect_valid_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: interrupt, then synchronous causes in flag
// bit order, then ERET. Build option EXC_TLB_EN enables the TLB causes.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [EXC_W-1:0] flags_i,
    input  logic             int_req_i,
    input  logic             eret_i,
    output logic             hit_o,
    output logic [7:0]       code_o,
    output logic             fetch_side_o
);

    logic [EXC_W-1:0] flags_eff;

`ifdef EXC_TLB_EN
    assign flags_eff = flags_i;
`else
    assign flags_eff = flags_i & ~EXC_TLB_MASK;
`endif

    // First set cause wins; fetch-side causes report the PC as bad address.
    always_comb begin
        hit_o        = 1'b1;
        code_o       = 8'h00;
        fetch_side_o = 1'b0;
        if (int_req_i)                   code_o = EXCT_INT;
        else if (flags_eff[EXC_ADEL_F]) begin code_o = EXCT_ADEL;   fetch_side_o = 1'b1; end
        else if (flags_eff[EXC_TLBR_I]) begin code_o = EXCT_TLBR_I; fetch_side_o = 1'b1; end
        else if (flags_eff[EXC_TLBI_I]) begin code_o = EXCT_TLBI_I; fetch_side_o = 1'b1; end
        else if (flags_eff[EXC_RI])      code_o = EXCT_RI;
        else if (flags_eff[EXC_CPU])     code_o = EXCT_CPU;
        else if (flags_eff[EXC_OV])      code_o = EXCT_OV;
        else if (flags_eff[EXC_TRAP])    code_o = EXCT_TRAP;
        else if (flags_eff[EXC_SYS])     code_o = EXCT_SYS;
        else if (flags_eff[EXC_BP])      code_o = EXCT_BP;
        else if (flags_eff[EXC_ADEL_D])  code_o = EXCT_ADEL;
        else if (flags_eff[EXC_ADES])    code_o = EXCT_ADES;
        else if (flags_eff[EXC_TLBR_D])  code_o = EXCT_TLBR_D;
        else if (flags_eff[EXC_TLBI_D])  code_o = EXCT_TLBI_D;
        else if (flags_eff[EXC_MOD])     code_o = EXCT_MOD;
        else if (eret_i)                 code_o = EXCT_ERET;
        else                             hit_o  = 1'b0;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the M stage and cp0: detects one event
// per valid instruction, commits it to cp0 for one cycle, then flushes and
// holds the redirect PC until fetch accepts it.
// Build option EXC_TLB_EN: TLB causes and the refill vector offset.
//
// state    | meaning
// IDLE     | watching M for an exception, interrupt or ERET
// COMMIT   | excepttype to cp0 this cycle, flush, redirect offered
// REDIRECT | flush held, redirect offered until fetch takes it
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_RESET = 32'hBFC00200
) (
    input  logic          clk,
    input  logic          rst,
    exc_ctrl_if.slave     bus
);

    exc_state_e  state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        delay_q, delay_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic [31:0] target_q, target_d;

    logic        int_req;
    logic        hit;
    logic [7:0]  code;
    logic        fetch_side;
    logic        detect;
    logic [31:0] vec_base;
    logic [11:0] vec_ofs;
    logic [31:0] target;

    // Status bits 0/1/2 are IE/EXL/ERL; these are the pre-exception values.
    assign int_req = bus.status_i[0] & ~bus.status_i[1] & ~bus.status_i[2] &
                     (|(bus.cause_i[15:8] & bus.status_i[15:8]));

    exc_prio_enc u_prio (
        .flags_i      (bus.exc_flags_i),
        .int_req_i    (int_req),
        .eret_i       (bus.eret_i),
        .hit_o        (hit),
        .code_o       (code),
        .fetch_side_o (fetch_side)
    );

    assign detect   = (state_q == ST_IDLE) & bus.inst_valid_i & ~bus.stallM_i & hit;
    assign vec_base = bus.status_i[22] ? VEC_RESET : {bus.ebase_i[31:12], 12'h000};

`ifdef EXC_TLB_EN
    assign vec_ofs = (is_tlb_refill(code) && !bus.status_i[1]) ? VEC_OFS_REFILL
                                                               : VEC_OFS_GENERAL;
`else
    assign vec_ofs = VEC_OFS_GENERAL;
`endif

    assign target = (code == EXCT_ERET) ? bus.epc_i : (vec_base + {20'h0, vec_ofs});

    // Next state and event capture; capture only happens on detection in IDLE.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pc_d      = pc_q;
        delay_d   = delay_q;
        badaddr_d = badaddr_q;
        target_d  = target_q;
        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    state_d   = ST_COMMIT;
                    code_d    = code;
                    pc_d      = bus.pc_i;
                    delay_d   = bus.in_delay_i;
                    badaddr_d = fetch_side ? bus.pc_i : bus.bad_addr_i;
                    target_d  = target;
                end
            end
            ST_COMMIT:   state_d = bus.redirect_ready_i ? ST_IDLE : ST_REDIRECT;
            ST_REDIRECT: state_d = bus.redirect_ready_i ? ST_IDLE : ST_REDIRECT;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and captured-event registers, synchronous reset to all zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= 8'h00;
            pc_q      <= 32'h0;
            delay_q   <= 1'b0;
            badaddr_q <= 32'h0;
            target_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            delay_q   <= delay_d;
            badaddr_q <= badaddr_d;
            target_q  <= target_d;
        end
    end

    assign bus.excepttype_o     = (state_q == ST_COMMIT) ? {24'h0, code_q} : 32'h0;
    assign bus.exc_pc_o         = pc_q;
    assign bus.exc_delay_o      = delay_q;
    assign bus.exc_badaddr_o    = badaddr_q;
    assign bus.flush_o          = (state_q != ST_IDLE);
    assign bus.redirect_valid_o = (state_q != ST_IDLE);
    assign bus.redirect_pc_o    = target_q;
    assign bus.busy_o           = (state_q != ST_IDLE);

    logic unused_bits;
    assign unused_bits = ^{bus.status_i[31:23], bus.status_i[21:16], bus.status_i[7:3],
                           bus.cause_i[31:16], bus.cause_i[7:0], bus.ebase_i[11:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    import exc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exc_ctrl_if bus ();
    exc_ctrl #(.VEC_RESET(32'hBFC00200)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic clear_inputs();
        bus.inst_valid_i     = 1'b0;
        bus.stallM_i         = 1'b0;
        bus.exc_flags_i      = '0;
        bus.eret_i           = 1'b0;
        bus.pc_i             = 32'h0;
        bus.in_delay_i       = 1'b0;
        bus.bad_addr_i       = 32'h0;
        bus.status_i         = 32'h0;
        bus.cause_i          = 32'h0;
        bus.epc_i            = 32'h0;
        bus.ebase_i          = 32'h80000000;
        bus.redirect_ready_i = 1'b1;
    endtask

    // Called at a negedge: one valid M cycle, returns at the next negedge.
    task automatic launch();
        bus.inst_valid_i = 1'b1;
        @(negedge clk);
        bus.inst_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.excepttype_o !== 32'h0) begin n_err++; $display("FAIL reset_excepttype got %h exp 0", bus.excepttype_o); end
        n_cmp++; if ({bus.flush_o, bus.redirect_valid_o, bus.busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {bus.flush_o, bus.redirect_valid_o, bus.busy_o}); end
        n_cmp++; if (bus.redirect_pc_o !== 32'h0 || bus.exc_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pcs got %h/%h exp 0/0", bus.redirect_pc_o, bus.exc_pc_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_syscall();
        clear_inputs();
        bus.exc_flags_i[EXC_SYS] = 1'b1;
        bus.pc_i       = 32'h80001000;
        bus.bad_addr_i = 32'h00001234;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h08) begin n_err++; $display("FAIL sys_code got %h exp 08", bus.excepttype_o); end
        n_cmp++; if (bus.exc_pc_o !== 32'h80001000 || bus.exc_delay_o !== 1'b0) begin n_err++; $display("FAIL sys_pc got %h/%b exp 80001000/0", bus.exc_pc_o, bus.exc_delay_o); end
        n_cmp++; if (bus.exc_badaddr_o !== 32'h00001234) begin n_err++; $display("FAIL sys_badaddr got %h exp 00001234", bus.exc_badaddr_o); end
        n_cmp++; if (bus.redirect_pc_o !== 32'h80000180) begin n_err++; $display("FAIL sys_target got %h exp 80000180", bus.redirect_pc_o); end
        n_cmp++; if ({bus.flush_o, bus.redirect_valid_o, bus.busy_o} !== 3'b111) begin n_err++; $display("FAIL sys_commit_flags got %b exp 111", {bus.flush_o, bus.redirect_valid_o, bus.busy_o}); end
        @(negedge clk);
        n_cmp++; if (bus.excepttype_o !== 32'h0 || bus.busy_o !== 1'b0) begin n_err++; $display("FAIL sys_idle got %h/%b exp 0/0", bus.excepttype_o, bus.busy_o); end
        n_cmp++; if (bus.exc_pc_o !== 32'h80001000) begin n_err++; $display("FAIL sys_hold_pc got %h exp 80001000", bus.exc_pc_o); end
    endtask

    task automatic test_int_priority();
        clear_inputs();
        bus.status_i = 32'h00000401;
        bus.cause_i  = 32'h00000400;
        bus.exc_flags_i[EXC_OV] = 1'b1;
        bus.pc_i = 32'h80000040;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h01) begin n_err++; $display("FAIL int_vs_ov got %h exp 01", bus.excepttype_o); end
        @(negedge clk);
        bus.status_i = 32'h00000403;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h0c) begin n_err++; $display("FAIL ov_exl got %h exp 0c", bus.excepttype_o); end
        @(negedge clk);
        bus.status_i = 32'h00000401;
        bus.exc_flags_i = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL int_no_valid got busy %b exp 0", bus.busy_o); end
    endtask

    task automatic test_stall();
        clear_inputs();
        bus.exc_flags_i[EXC_SYS] = 1'b1;
        bus.stallM_i = 1'b1;
        launch();
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.excepttype_o !== 32'h0) begin n_err++; $display("FAIL stall_no_event got %b/%h exp 0/0", bus.busy_o, bus.excepttype_o); end
        bus.stallM_i = 1'b0;
    endtask

    task automatic test_eret();
        clear_inputs();
        bus.eret_i = 1'b1;
        bus.epc_i  = 32'hBFC00380;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h0e) begin n_err++; $display("FAIL eret_code got %h exp 0e", bus.excepttype_o); end
        n_cmp++; if (bus.redirect_pc_o !== 32'hBFC00380) begin n_err++; $display("FAIL eret_target got %h exp bfc00380", bus.redirect_pc_o); end
        @(negedge clk);
        bus.exc_flags_i[EXC_BP] = 1'b1;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h09) begin n_err++; $display("FAIL eret_loses got %h exp 09", bus.excepttype_o); end
        @(negedge clk);
    endtask

    task automatic test_adel_fetch();
        clear_inputs();
        bus.exc_flags_i[EXC_ADEL_F] = 1'b1;
        bus.exc_flags_i[EXC_ADES]   = 1'b1;
        bus.pc_i       = 32'h80002006;
        bus.in_delay_i = 1'b1;
        bus.bad_addr_i = 32'h0000dead;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h04) begin n_err++; $display("FAIL adelf_code got %h exp 04", bus.excepttype_o); end
        n_cmp++; if (bus.exc_badaddr_o !== 32'h80002006 || bus.exc_delay_o !== 1'b1) begin n_err++; $display("FAIL adelf_badaddr got %h/%b exp 80002006/1", bus.exc_badaddr_o, bus.exc_delay_o); end
        @(negedge clk);
    endtask

    task automatic test_tlb_refill();
        clear_inputs();
        bus.exc_flags_i[EXC_TLBR_D] = 1'b1;
        bus.status_i   = 32'h00400000;
        bus.bad_addr_i = 32'h00402000;
        bus.pc_i       = 32'h80003000;
        launch();
`ifdef EXC_TLB_EN
        n_cmp++; if (bus.excepttype_o !== 32'h12) begin n_err++; $display("FAIL tlbr_code got %h exp 12", bus.excepttype_o); end
        n_cmp++; if (bus.exc_badaddr_o !== 32'h00402000) begin n_err++; $display("FAIL tlbr_badaddr got %h exp 00402000", bus.exc_badaddr_o); end
        n_cmp++; if (bus.redirect_pc_o !== 32'hBFC00200) begin n_err++; $display("FAIL tlbr_target got %h exp bfc00200", bus.redirect_pc_o); end
        @(negedge clk);
        bus.status_i = 32'h00400002;
        launch();
        n_cmp++; if (bus.redirect_pc_o !== 32'hBFC00380) begin n_err++; $display("FAIL tlbr_exl_target got %h exp bfc00380", bus.redirect_pc_o); end
`else
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.excepttype_o !== 32'h0) begin n_err++; $display("FAIL tlbr_disabled got %b/%h exp 0/0", bus.busy_o, bus.excepttype_o); end
        bus.exc_flags_i[EXC_ADES] = 1'b1;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h05 || bus.redirect_pc_o !== 32'hBFC00380) begin n_err++; $display("FAIL ades_bev got %h/%h exp 05/bfc00380", bus.excepttype_o, bus.redirect_pc_o); end
`endif
        @(negedge clk);
    endtask

    task automatic test_hold_redirect();
        clear_inputs();
        bus.exc_flags_i[EXC_TRAP] = 1'b1;
        bus.redirect_ready_i = 1'b0;
        launch();
        n_cmp++; if (bus.excepttype_o !== 32'h0d || bus.flush_o !== 1'b1 || bus.redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_commit got %h/%b/%b exp 0d/1/1", bus.excepttype_o, bus.flush_o, bus.redirect_valid_o); end
        bus.stallM_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.excepttype_o !== 32'h0 || bus.flush_o !== 1'b1 || bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h80000180) begin
                n_err++; $display("FAIL hold_redirect_%0d got %h/%b/%b/%h exp 0/1/1/80000180", i, bus.excepttype_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o);
            end
            if (i == 3) bus.redirect_ready_i = 1'b1;
        end
        bus.stallM_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.flush_o !== 1'b0 || bus.redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_release got %b/%b exp 0/0", bus.flush_o, bus.redirect_valid_o); end
    endtask

    task automatic test_reset_mid_redirect();
        clear_inputs();
        bus.exc_flags_i[EXC_RI] = 1'b1;
        bus.pc_i = 32'h80004000;
        bus.redirect_ready_i = 1'b0;
        launch();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.flush_o, bus.redirect_valid_o, bus.busy_o} !== 3'b000 || bus.excepttype_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_flags got %b/%h exp 000/0", {bus.flush_o, bus.redirect_valid_o, bus.busy_o}, bus.excepttype_o); end
        n_cmp++; if (bus.redirect_pc_o !== 32'h0 || bus.exc_pc_o !== 32'h0 || bus.exc_badaddr_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h/%h/%h exp 0/0/0", bus.redirect_pc_o, bus.exc_pc_o, bus.exc_badaddr_o); end
        rst = 1'b0;
        bus.exc_flags_i = '0;
        @(negedge clk);
        n_cmp++; if (bus.excepttype_o !== 32'h0 || bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got %h/%b exp 0/0", bus.excepttype_o, bus.busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        clear_inputs();
        bus.exc_flags_i[EXC_SYS] = 1'b1;
        bus.inst_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = (i % 2 == 0) ? 32'h08 : 32'h0;
            n_cmp++; if (bus.excepttype_o !== exp) begin n_err++; $display("FAIL b2b_%0d got %h exp %h", i, bus.excepttype_o, exp); end
        end
        bus.inst_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_int_priority();
        test_stall();
        test_eret();
        test_adel_fetch();
        test_tlb_refill();
        test_hold_redirect();
        test_reset_mid_redirect();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
